// File: rtl/uart001_pkg.sv
// Shared definitions for the uart001 RX framer: state encoding, parameter defaults and checksum helpers.
package uart001_pkg;

   localparam logic [7:0] HDR_DEFAULT         = 8'hA5;
   localparam int         MAX_LEN_DEFAULT     = 16;
   localparam int         TIMEOUT_CYC_DEFAULT = 208320;

   localparam int BUF_DEPTH = 16;
   localparam int BUF_AW    = 4;

   // Fixed encodings kept as plain constants so older code that compares raw state bits still works.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LEN     = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_CSUM    = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_LEN     = ST_LEN,
      S_PAYLOAD = ST_PAYLOAD,
      S_CSUM    = ST_CSUM,
      S_DRAIN   = ST_DRAIN
   } rx_state_e;

   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
      return sum + b;
   endfunction

   function automatic logic len_ok(input logic [7:0] len, input int max_len);
      return (len != 8'd0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/uart001_frame_buf.sv
// 16-entry payload store for one frame: synchronous write port, asynchronous read port.
module uart001_frame_buf
   import uart001_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [BUF_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BUF_AW-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart001_rx_ctrl.sv
// UART frame receiver: parses HDR, LEN, payload, CSUM and replays a verified payload as a ready/valid stream.
// Defining UART001_RX_CTRL_TIMEOUT_EN adds an inter-byte timeout that abandons a stalled frame.
module uart001_rx_ctrl
   import uart001_pkg::*;
#(
   parameter logic [7:0] HDR         = HDR_DEFAULT,
   parameter int         MAX_LEN     = MAX_LEN_DEFAULT,
   parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  uart_rx_data_i,
   input  logic        uart_rx_done_i,
   output logic [7:0]  pay_data_o,
   output logic        pay_valid_o,
   input  logic        pay_ready_i,
   output logic        pay_last_o,
   output logic        err_len_o,
   output logic        err_csum_o,
   output logic        err_timeout_o,
   output logic        err_ovf_o,
   output logic [15:0] frame_cnt_o
);

   rx_state_e         state_q;
   logic [4:0]        len_q;
   logic [BUF_AW-1:0] wr_ptr_q;
   logic [BUF_AW-1:0] rd_ptr_q;
   logic [7:0]        sum_q;
   logic [15:0]       frame_cnt_q;
   logic              err_len_p1;
   logic              err_csum_p1;
   logic              err_ovf_p1;
   logic              to_hit;
   logic              wr_last;
   logic              rd_last;
   logic              xfer;
   logic              buf_we;
   logic [7:0]        buf_rdata;

   if (MAX_LEN < 1 || MAX_LEN > BUF_DEPTH) begin : g_bad_max_len
      $error("uart001_rx_ctrl: MAX_LEN must lie in 1..16");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("uart001_rx_ctrl: TIMEOUT_CYC must be at least 1");
   end

   assign wr_last     = ({1'b0, wr_ptr_q} == (len_q - 5'd1));
   assign rd_last     = ({1'b0, rd_ptr_q} == (len_q - 5'd1));
   assign pay_valid_o = (state_q == S_DRAIN);
   assign xfer        = pay_valid_o & pay_ready_i;
   assign buf_we      = (state_q == S_PAYLOAD) & uart_rx_done_i;

   uart001_frame_buf #(
      .DATA_W (8)
   ) u_frame_buf (
      .clk_i (clk_i),
      .we    (buf_we),
      .waddr (wr_ptr_q),
      .wdata (uart_rx_data_i),
      .raddr (rd_ptr_q),
      .rdata (buf_rdata)
   );

   // Stage p1: frame FSM and registered error pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sum_q       <= '0;
         frame_cnt_q <= '0;
         err_len_p1  <= 1'b0;
         err_csum_p1 <= 1'b0;
         err_ovf_p1  <= 1'b0;
      end else begin
         err_len_p1  <= 1'b0;
         err_csum_p1 <= 1'b0;
         err_ovf_p1  <= 1'b0;
         if (to_hit) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (uart_rx_done_i && (uart_rx_data_i == HDR)) begin
                     state_q <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (uart_rx_done_i) begin
                     if (len_ok(uart_rx_data_i, MAX_LEN)) begin
                        len_q    <= uart_rx_data_i[4:0];
                        sum_q    <= uart_rx_data_i;
                        wr_ptr_q <= '0;
                        state_q  <= S_PAYLOAD;
                     end else begin
                        err_len_p1 <= 1'b1;
                        state_q    <= S_IDLE;
                     end
                  end
               end
               S_PAYLOAD: begin
                  if (uart_rx_done_i) begin
                     sum_q    <= csum_add(sum_q, uart_rx_data_i);
                     wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
                     if (wr_last) begin
                        state_q <= S_CSUM;
                     end
                  end
               end
               S_CSUM: begin
                  if (uart_rx_done_i) begin
                     if (uart_rx_data_i == sum_q) begin
                        rd_ptr_q <= '0;
                        state_q  <= S_DRAIN;
                     end else begin
                        err_csum_p1 <= 1'b1;
                        state_q     <= S_IDLE;
                     end
                  end
               end
               S_DRAIN: begin
                  // The buffer holds only one frame, so a byte arriving now is dropped, not queued.
                  if (uart_rx_done_i) begin
                     err_ovf_p1 <= 1'b1;
                  end
                  if (xfer) begin
                     if (rd_last) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= S_IDLE;
                     end else begin
                        rd_ptr_q <= rd_ptr_q + BUF_AW'(1);
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

`ifdef UART001_RX_CTRL_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TO_W-1:0] to_cnt_q;
   logic            frame_open;
   logic            err_to_p1;

   assign frame_open = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
   assign to_hit     = frame_open && !uart_rx_done_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   // Stage p1: inter-byte timeout, idle while waiting for a header or draining
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt_q  <= '0;
         err_to_p1 <= 1'b0;
      end else begin
         err_to_p1 <= to_hit;
         if (!frame_open || uart_rx_done_i || to_hit) begin
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end
      end
   end

   assign err_timeout_o = err_to_p1;
`else
   assign to_hit        = 1'b0;
   assign err_timeout_o = 1'b0;
`endif

   assign pay_data_o  = pay_valid_o ? buf_rdata : 8'h00;
   assign pay_last_o  = pay_valid_o & rd_last;
   assign err_len_o   = err_len_p1;
   assign err_csum_o  = err_csum_p1;
   assign err_ovf_o   = err_ovf_p1;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart001_rx_ctrl.sv
// Bench for uart001_rx_ctrl: vector table, hand-written corner sequences and randomized frames vs a frame-level model.
`timescale 1ns/1ps
module tb_uart001_rx_ctrl;

   localparam logic [7:0] HDR         = 8'hA5;
   localparam int         MAX_LEN     = 16;
   localparam int         TIMEOUT_CYC = 40;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  uart_rx_data_i = 8'h00;
   logic        uart_rx_done_i = 1'b0;
   logic [7:0]  pay_data_o;
   logic        pay_valid_o;
   logic        pay_ready_i = 1'b0;
   logic        pay_last_o;
   logic        err_len_o, err_csum_o, err_timeout_o, err_ovf_o;
   logic [15:0] frame_cnt_o;

   always #5 clk_i = ~clk_i;

   uart001_rx_ctrl #(
      .HDR         (HDR),
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .uart_rx_data_i (uart_rx_data_i),
      .uart_rx_done_i (uart_rx_done_i),
      .pay_data_o     (pay_data_o),
      .pay_valid_o    (pay_valid_o),
      .pay_ready_i    (pay_ready_i),
      .pay_last_o     (pay_last_o),
      .err_len_o      (err_len_o),
      .err_csum_o     (err_csum_o),
      .err_timeout_o  (err_timeout_o),
      .err_ovf_o      (err_ovf_o),
      .frame_cnt_o    (frame_cnt_o)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int ready_mode = 1;
   int exp_frames = 0;

   logic [8:0] obs_q[$];
   int n_len = 0;
   int n_csum = 0;
   int n_ovf = 0;
   int n_to = 0;

   typedef struct {
      int           nb;
      logic [159:0] bytes;
      int           npay;
      logic [127:0] pay;
      int           elen;
      int           ecsum;
   } vec_t;

   vec_t vecs[10];

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (pay_valid_o && pay_ready_i) obs_q.push_back({pay_last_o, pay_data_o});
         if (err_len_o)     n_len++;
         if (err_csum_o)    n_csum++;
         if (err_ovf_o)     n_ovf++;
         if (err_timeout_o) n_to++;
      end
   end

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (ready_mode)
            0:       pay_ready_i = 1'b0;
            1:       pay_ready_i = 1'b1;
            default: pay_ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk_i);
      #1;
      uart_rx_data_i = b;
      uart_rx_done_i = 1'b1;
      @(posedge clk_i);
      #1;
      uart_rx_done_i = 1'b0;
   endtask

   task automatic wait_stream(input int target);
      int k;
      k = 0;
      while (obs_q.size() < target && k < 3000) begin
         @(negedge clk_i);
         k++;
      end
      if (obs_q.size() < target) check("stream_wait", obs_q.size(), target);
      repeat (3) @(negedge clk_i);
   endtask

   task automatic apply_vec(input int id, input vec_t v);
      int b_len, b_csum, b_ovf, b_obs;
      logic [7:0] pb;
      b_len = n_len; b_csum = n_csum; b_ovf = n_ovf; b_obs = obs_q.size();
      for (int k = 0; k < v.nb; k++) send_byte(v.bytes[(v.nb-1-k)*8 +: 8]);
      wait_stream(b_obs + v.npay);
      if (v.npay > 0) exp_frames++;
      check($sformatf("vec%0d_len_err", id), n_len - b_len, v.elen);
      check($sformatf("vec%0d_csum_err", id), n_csum - b_csum, v.ecsum);
      check($sformatf("vec%0d_ovf_err", id), n_ovf - b_ovf, 0);
      check($sformatf("vec%0d_count", id), obs_q.size() - b_obs, v.npay);
      for (int k = 0; k < v.npay; k++) begin
         pb = v.pay[(v.npay-1-k)*8 +: 8];
         check($sformatf("vec%0d_byte%0d", id, k), obs_q[b_obs+k], {(k == v.npay-1), pb});
      end
      check($sformatf("vec%0d_frame_cnt", id), frame_cnt_o, exp_frames);
      check($sformatf("vec%0d_idle", id), pay_valid_o, 0);
   endtask

   task automatic run_random(input int nframes);
      logic [7:0] fb[$];
      logic [8:0] exp_q[$];
      logic [7:0] b;
      int kind, len, sum, e_len, e_csum, b_obs, b_len, b_csum, b_ovf, b_to;
      e_len = 0; e_csum = 0;
      b_obs = obs_q.size(); b_len = n_len; b_csum = n_csum; b_ovf = n_ovf; b_to = n_to;
      ready_mode = 2;
      for (int f = 0; f < nframes; f++) begin
         fb.delete();
         kind = $urandom_range(0, 9);
         if (kind == 9) begin
            repeat ($urandom_range(1, 3)) begin
               do b = 8'($urandom_range(0, 255)); while (b == HDR);
               fb.push_back(b);
            end
         end else if (kind == 8) begin
            fb.push_back(HDR);
            fb.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            e_len++;
         end else begin
            len = $urandom_range(1, MAX_LEN);
            sum = len;
            fb.push_back(HDR);
            fb.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
               b = 8'($urandom_range(0, 255));
               sum += b;
               fb.push_back(b);
               if (kind <= 5) exp_q.push_back({(i == len-1), b});
            end
            if (kind <= 5) begin
               fb.push_back(8'(sum % 256));
               exp_frames++;
            end else begin
               fb.push_back(8'(sum % 256) ^ 8'($urandom_range(1, 255)));
               e_csum++;
            end
         end
         foreach (fb[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            send_byte(fb[i]);
         end
         wait_stream(b_obs + exp_q.size());
      end
      check("rnd_count", obs_q.size() - b_obs, exp_q.size());
      foreach (exp_q[i]) check($sformatf("rnd_byte%0d", i), obs_q[b_obs+i], exp_q[i]);
      check("rnd_len_err", n_len - b_len, e_len);
      check("rnd_csum_err", n_csum - b_csum, e_csum);
      check("rnd_ovf_err", n_ovf - b_ovf, 0);
      check("rnd_to_err", n_to - b_to, 0);
      check("rnd_frame_cnt", frame_cnt_o, exp_frames);
   endtask

   initial begin
      logic [159:0] bv;
      logic [127:0] pv;
      int b_obs, b_ovf, b_to;

      vecs[0] = '{nb:6, bytes:{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h69}, npay:3, pay:{8'h11,8'h22,8'h33}, elen:0, ecsum:0};
      vecs[1] = '{nb:6, bytes:{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h68}, npay:0, pay:'0, elen:0, ecsum:1};
      vecs[2] = '{nb:2, bytes:{8'hA5,8'h00}, npay:0, pay:'0, elen:1, ecsum:0};
      vecs[3] = '{nb:2, bytes:{8'hA5,8'h11}, npay:0, pay:'0, elen:1, ecsum:0};
      vecs[4] = '{nb:6, bytes:{8'h12,8'h34,8'hA5,8'h01,8'h7E,8'h7F}, npay:1, pay:{8'h7E}, elen:0, ecsum:0};
      bv = {8'hA5, 8'h10};
      pv = '0;
      for (int i = 1; i <= 16; i++) begin
         bv = (bv << 8) | 160'(i);
         pv = (pv << 8) | 128'(i);
      end
      bv = (bv << 8) | 160'(8'h98);
      vecs[5] = '{nb:19, bytes:bv, npay:16, pay:pv, elen:0, ecsum:0};
      vecs[6] = '{nb:2, bytes:{8'hA5,8'hFF}, npay:0, pay:'0, elen:1, ecsum:0};
      vecs[7] = '{nb:4, bytes:{8'hA5,8'h01,8'h00,8'h01}, npay:1, pay:{8'h00}, elen:0, ecsum:0};
      vecs[8] = '{nb:5, bytes:{8'hA5,8'h02,8'hFF,8'hFF,8'h00}, npay:2, pay:{8'hFF,8'hFF}, elen:0, ecsum:0};
      vecs[9] = '{nb:5, bytes:{8'hA5,8'h02,8'hA5,8'hA5,8'h4C}, npay:2, pay:{8'hA5,8'hA5}, elen:0, ecsum:0};

      repeat (3) @(negedge clk_i);
      check("rst_valid", pay_valid_o, 0);
      check("rst_last", pay_last_o, 0);
      check("rst_data", pay_data_o, 8'h00);
      check("rst_errs", {err_len_o, err_csum_o, err_timeout_o, err_ovf_o}, 4'b0000);
      check("rst_frame_cnt", frame_cnt_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      send_byte(HDR);
      send_byte(8'h00);
      @(negedge clk_i);
      check("len_pulse_on", err_len_o, 1);
      @(negedge clk_i);
      check("len_pulse_off", err_len_o, 0);

      ready_mode = 1;
      for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

      ready_mode = 0;
      b_obs = obs_q.size(); b_ovf = n_ovf; b_to = n_to;
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      @(negedge clk_i);
      check("pre_csum_valid", pay_valid_o, 0);
      send_byte(8'h69);
      @(negedge clk_i);
      check("drain_start", {pay_valid_o, pay_last_o, pay_data_o}, {1'b1, 1'b0, 8'h11});
      for (int c = 0; c < 100; c++) begin
         if (c == 50) send_byte(8'h55);
         @(negedge clk_i);
         check($sformatf("hold%0d", c), {pay_valid_o, pay_last_o, pay_data_o}, {1'b1, 1'b0, 8'h11});
      end
      check("ovf_pulse", n_ovf - b_ovf, 1);
      check("no_timeout_in_drain", n_to - b_to, 0);
      ready_mode = 1;
      wait_stream(b_obs + 3);
      exp_frames++;
      check("ovf_count", obs_q.size() - b_obs, 3);
      check("ovf_byte0", obs_q[b_obs], {1'b0, 8'h11});
      check("ovf_byte1", obs_q[b_obs+1], {1'b0, 8'h22});
      check("ovf_byte2", obs_q[b_obs+2], {1'b1, 8'h33});
      check("ovf_frame_cnt", frame_cnt_o, exp_frames);

      b_to = n_to;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      repeat (TIMEOUT_CYC + 5) @(negedge clk_i);
`ifdef UART001_RX_CTRL_TIMEOUT_EN
      check("to_pulse", n_to - b_to, 1);
      check("to_idle", pay_valid_o, 0);
      b_obs = obs_q.size();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      wait_stream(b_obs + 1);
      exp_frames++;
      check("to_recover_byte", obs_q[b_obs], {1'b1, 8'h7E});
      check("to_recover_frame_cnt", frame_cnt_o, exp_frames);
      b_to = n_to;
      repeat (TIMEOUT_CYC + 5) @(negedge clk_i);
      check("to_quiet_in_idle", n_to - b_to, 0);
`else
      check("to_absent", n_to - b_to, 0);
      b_obs = obs_q.size();
      send_byte(8'h22); send_byte(8'h35);
      wait_stream(b_obs + 2);
      exp_frames++;
      check("late_byte0", obs_q[b_obs], {1'b0, 8'h11});
      check("late_byte1", obs_q[b_obs+1], {1'b1, 8'h22});
      check("late_frame_cnt", frame_cnt_o, exp_frames);
`endif

      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      check("mid_rst_valid", pay_valid_o, 0);
      check("mid_rst_data", pay_data_o, 8'h00);
      check("mid_rst_errs", {err_len_o, err_csum_o, err_timeout_o, err_ovf_o, pay_last_o}, 5'b00000);
      check("mid_rst_frame_cnt", frame_cnt_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      exp_frames = 0;
      b_obs = obs_q.size();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
      wait_stream(b_obs + 3);
      exp_frames++;
      check("post_rst_byte0", obs_q[b_obs], {1'b0, 8'h11});
      check("post_rst_byte1", obs_q[b_obs+1], {1'b0, 8'h22});
      check("post_rst_byte2", obs_q[b_obs+2], {1'b1, 8'h33});
      check("post_rst_frame_cnt", frame_cnt_o, exp_frames);

      run_random(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
